// File: rtl/fibo_arb_pkg.sv
// fibo_arb_pkg: shared state encoding and default sizing for the fibonacci request arbiter.
package fibo_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int SIZE_DEF    = 4;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int IDX_W       = $clog2(NREQ_DEF);
endpackage

// File: rtl/fibo_rr_pick.sv
// fibo_rr_pick: combinational round-robin picker; first set request searching upward from ptr_i with wrap.
module fibo_rr_pick
    import fibo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = IDX_W
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            vld_o,
    output logic [IW-1:0]   idx_o
);
    logic [IW-1:0] j;
    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        j     = '0;
        // Walk downward so the candidate closest to the pointer is written last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % NREQ);
            if (req_i[j]) idx_o = j;
        end
    end
endmodule

// File: rtl/fibo_request_arbiter.sv
// fibo_request_arbiter: shares one fibonacci calculator among NREQ requesters, one job at a time, round-robin.
// Optional watchdog abort enabled by defining FIBO_TIMEOUT_EN.
module fibo_request_arbiter
    import fibo_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int SIZE    = SIZE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*SIZE-1:0] REQ_COUNT,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      RESP_VALID,
    output logic [SIZE-1:0]      RESP_DATA,
    output logic                 RESP_ERR,
    output logic                 BUSY,
    output logic                 CALC_START,
    output logic [SIZE-1:0]      CALC_COUNT,
    input  logic                 CALC_DONE,
    input  logic [SIZE-1:0]      CALC_DATA
);
    localparam int IW = $clog2(NREQ);

    state_t            state_q;
    logic [IW-1:0]     ptr_q, idx_q, pick_idx;
    logic              pick_vld, start_q, guard_q;
    logic [NREQ-1:0]   gnt_q, valid_q;
    logic [SIZE-1:0]   count_q, data_q, pick_cnt;

    fibo_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign pick_cnt = SIZE'(REQ_COUNT >> (int'(pick_idx) * SIZE));

`ifdef FIBO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wdog_q;
    logic          err_q;
    assign RESP_ERR = err_q;
`else
    assign RESP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            guard_q <= 1'b0;
            gnt_q   <= '0;
            valid_q <= '0;
            count_q <= '0;
            data_q  <= '0;
`ifdef FIBO_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (pick_vld) begin
                    state_q <= ISSUE;
                    idx_q   <= pick_idx;
                    gnt_q   <= NREQ'(1) << pick_idx;
                    start_q <= 1'b1;
                    count_q <= pick_cnt;
                end
                ISSUE: begin
                    state_q <= WAIT;
                    start_q <= 1'b0;
                    guard_q <= 1'b1;
`ifdef FIBO_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                WAIT: begin
                    // The guard cycle masks a DONE left high by the previous job.
                    guard_q <= 1'b0;
`ifdef FIBO_TIMEOUT_EN
                    wdog_q  <= wdog_q + 1'b1;
`endif
                    if (!guard_q && CALC_DONE) begin
                        state_q <= RESP;
                        valid_q <= gnt_q;
                        data_q  <= CALC_DATA;
                    end
`ifdef FIBO_TIMEOUT_EN
                    else if (int'(wdog_q) + 1 >= TIMEOUT) begin
                        state_q <= RESP;
                        valid_q <= gnt_q;
                        data_q  <= '0;
                        err_q   <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    valid_q <= '0;
                    ptr_q   <= (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
`ifdef FIBO_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign GNT        = gnt_q;
    assign RESP_VALID = valid_q;
    assign RESP_DATA  = data_q;
    assign BUSY       = state_q != IDLE;
    assign CALC_START = start_q;
    assign CALC_COUNT = count_q;
endmodule
